// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding, lamp codes and timer sizing for the phase controller.
package traffic_pkg;
  typedef enum logic [1:0] {ALL_RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, FLASH = 2'd3} phase_t;
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
  localparam logic [1:0] LIGHT_DARK   = 2'b11;
  // The timer only ever holds TIME-1, so the longest phase needs clog2(max) bits (at least one).
  function automatic int timer_width(int g, int y, int a, int f);
    int m;
    m = g;
    m = y > m ? y : m;
    m = a > m ? a : m;
    m = f > m ? f : m;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: sensor/preempt inputs and lamp/status outputs of the phase controller.
//   master: front-end side (drives veh_req, preempt_valid, preempt_dir, flash_mode)
//   slave:  controller side (drives light, active_dir, phase, preempt_ack)
interface traffic_phase_controller_if #(
  parameter int NUM_DIRS = 4,
  parameter int DIR_W    = $clog2(NUM_DIRS)
);
  logic [NUM_DIRS-1:0]   veh_req;
  logic                  preempt_valid;
  logic [DIR_W-1:0]      preempt_dir;
  logic                  flash_mode;
  logic [2*NUM_DIRS-1:0] light;
  logic [DIR_W-1:0]      active_dir;
  logic [1:0]            phase;
  logic                  preempt_ack;
  modport master (
    output veh_req, preempt_valid, preempt_dir, flash_mode,
    input  light, active_dir, phase, preempt_ack
  );
  modport slave (
    input  veh_req, preempt_valid, preempt_dir, flash_mode,
    output light, active_dir, phase, preempt_ack
  );
endinterface

// File: rtl/traffic_rr_select.sv
// traffic_rr_select: combinational round-robin finder.
//   req     in  per-approach demand
//   last    in  approach served last; search starts at last+1 and checks last itself last
//   winner  out first requesting approach in that order (last when nothing requests)
//   any_req out at least one approach requests
module traffic_rr_select #(
  parameter int NUM_DIRS = 4,
  parameter int DIR_W    = $clog2(NUM_DIRS)
) (
  input  logic [NUM_DIRS-1:0] req,
  input  logic [DIR_W-1:0]    last,
  output logic [DIR_W-1:0]    winner,
  output logic                any_req
);
  logic [DIR_W-1:0] idx;
  assign any_req = |req;
  // Walk from the farthest candidate to the nearest so the nearest requester overwrites the rest.
  always_comb begin
    winner = last;
    idx    = '0;
    for (int i = NUM_DIRS; i >= 1; i--) begin
      idx = DIR_W'((32'(last) + 32'(i)) % NUM_DIRS);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-approach green/yellow/all-red sequencer with demand skipping, preemption and flash.
//   clk, reset  clock and asynchronous active-high reset
//   bus.slave   veh_req, preempt_valid, preempt_dir, flash_mode in; light, active_dir, phase, preempt_ack out
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS     = 4,
  parameter int GREEN_TIME   = 5,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int FLASH_TIME   = 3,
  parameter int DIR_W        = $clog2(NUM_DIRS)
) (
  input logic clk,
  input logic reset,
  traffic_phase_controller_if.slave bus
);
  localparam int TW = timer_width(GREEN_TIME, YELLOW_TIME, ALL_RED_TIME, FLASH_TIME);
  localparam logic [TW-1:0] G_LD = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] Y_LD = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] A_LD = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] F_LD = TW'(FLASH_TIME - 1);
  phase_t                state;
  logic [TW-1:0]         timer;
  logic [DIR_W-1:0]      dir;
  logic                  flash_bit;
  logic                  preempt_ack;
  logic [DIR_W-1:0]      winner;
  logic                  any_req;
  logic [DIR_W-1:0]      next_dir;
  logic                  pv;
  logic [2*NUM_DIRS-1:0] light;
  // An out-of-range target (possible when NUM_DIRS is not a power of two) is treated as no request.
  assign pv       = bus.preempt_valid && (32'(bus.preempt_dir) < NUM_DIRS);
  assign next_dir = DIR_W'((32'(dir) + 32'd1) % NUM_DIRS);
  traffic_rr_select #(.NUM_DIRS(NUM_DIRS), .DIR_W(DIR_W)) u_rr (
    .req(bus.veh_req),
    .last(dir),
    .winner(winner),
    .any_req(any_req)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= ALL_RED;
      timer       <= A_LD;
      dir         <= DIR_W'(NUM_DIRS - 1);
      flash_bit   <= 1'b0;
      preempt_ack <= 1'b0;
    end else begin
      preempt_ack <= 1'b0;
      case (state)
        ALL_RED:
          if (timer != '0) timer <= timer - 1'b1;
          else if (pv) begin
            state       <= GREEN;
            dir         <= bus.preempt_dir;
            timer       <= G_LD;
            preempt_ack <= 1'b1;
          end else if (bus.flash_mode) begin
            state <= FLASH;
            timer <= F_LD;
          end else begin
            state <= GREEN;
            dir   <= any_req ? winner : next_dir;
            timer <= G_LD;
          end
        GREEN:
          // Preemption for the served approach freezes the green; for any other it cuts straight to yellow.
          if (pv && bus.preempt_dir == dir) begin
            timer       <= G_LD;
            preempt_ack <= 1'b1;
          end else if (pv || timer == '0) begin
            state <= YELLOW;
            timer <= Y_LD;
          end else timer <= timer - 1'b1;
        YELLOW:
          if (timer == '0) begin
            state <= ALL_RED;
            timer <= A_LD;
          end else timer <= timer - 1'b1;
        FLASH:
          if (pv || !bus.flash_mode) begin
            state     <= ALL_RED;
            timer     <= A_LD;
            flash_bit <= 1'b0;
          end else if (timer == '0) begin
            flash_bit <= ~flash_bit;
            timer     <= F_LD;
          end else timer <= timer - 1'b1;
      endcase
    end
  always_comb begin
    light = '0;
    for (int i = 0; i < NUM_DIRS; i++)
      light[2*i +: 2] = state == FLASH ? (flash_bit ? LIGHT_DARK : LIGHT_YELLOW) :
                        DIR_W'(i) != dir ? LIGHT_RED :
                        state == GREEN ? LIGHT_GREEN :
                        state == YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  end
  assign bus.light       = light;
  assign bus.active_dir  = dir;
  assign bus.phase       = state;
  assign bus.preempt_ack = preempt_ack;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: table-driven check of the phase controller (4-approach and 3-approach instances).
module tb_traffic_phase_controller;
  logic clk;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0]  vr;
    bit          pv;
    logic [2:0]  pd;
    bit          fm;
    logic [15:0] light;
    logic [1:0]  ph;
    logic [2:0]  dir;
    bit          ack;
  } vec_t;
  vec_t vq[$];
  traffic_phase_controller_if #(.NUM_DIRS(4)) bus4 ();
  traffic_phase_controller_if #(.NUM_DIRS(3)) bus3 ();
  traffic_phase_controller #(.NUM_DIRS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  traffic_phase_controller #(.NUM_DIRS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of test first");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] exp_light(int n, int ph, int d, bit dark);
    logic [15:0] l;
    l = '0;
    for (int i = 0; i < n; i++)
      l[2*i +: 2] = ph == 3 ? (dark ? 2'b11 : 2'b01) : i != d ? 2'b00 :
                    ph == 1 ? 2'b10 : ph == 2 ? 2'b01 : 2'b00;
    return l;
  endfunction
  task automatic seg(input int cnt, input logic [7:0] vr, input bit pv, input int pd, input bit fm,
                     input int ph, input int d, input bit ack, input bit dark = 1'b0, input int n = 4);
    vec_t v;
    for (int k = 0; k < cnt; k++) begin
      v.vr = vr; v.pv = pv; v.pd = 3'(pd); v.fm = fm;
      v.light = exp_light(n, ph, d, dark); v.ph = 2'(ph); v.dir = 3'(d); v.ack = ack;
      vq.push_back(v);
    end
  endtask
  // Fixed-cycle rotation with no demand: cycle 0 is the post-reset all-red, then 5 green / 2 yellow / 1 red per approach.
  task automatic rot(input int n, input int cycles, input bit pv, input int pd);
    int r;
    seg(1, 8'h00, pv, pd, 1'b0, 0, n - 1, 1'b0, 1'b0, n);
    for (int c = 1; c < cycles; c++) begin
      r = (c - 1) % 8;
      seg(1, 8'h00, pv, pd, 1'b0, r < 5 ? 1 : r < 7 ? 2 : 0, ((c - 1) / 8) % n, 1'b0, 1'b0, n);
    end
  endtask
  task automatic drive(input bit sel, input vec_t v);
    if (sel) begin
      bus3.veh_req = v.vr[2:0]; bus3.preempt_valid = v.pv; bus3.preempt_dir = v.pd[1:0]; bus3.flash_mode = v.fm;
    end else begin
      bus4.veh_req = v.vr[3:0]; bus4.preempt_valid = v.pv; bus4.preempt_dir = v.pd[1:0]; bus4.flash_mode = v.fm;
    end
  endtask
  task automatic run(input string tag, input bit sel);
    foreach (vq[k]) begin
      drive(sel, vq[k]);
      check($sformatf("%s[%0d] light", tag, k), sel ? 32'(bus3.light) : 32'(bus4.light), 32'(vq[k].light));
      check($sformatf("%s[%0d] phase", tag, k), sel ? 32'(bus3.phase) : 32'(bus4.phase), 32'(vq[k].ph));
      check($sformatf("%s[%0d] active_dir", tag, k), sel ? 32'(bus3.active_dir) : 32'(bus4.active_dir), 32'(vq[k].dir));
      check($sformatf("%s[%0d] preempt_ack", tag, k), sel ? 32'(bus3.preempt_ack) : 32'(bus4.preempt_ack), 32'(vq[k].ack));
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask
  task automatic do_reset(input string tag);
    vec_t z;
    z = '{default: '0};
    reset = 1'b1;
    drive(1'b0, z);
    drive(1'b1, z);
    @(posedge clk);
    #1;
    check({tag, " reset light"}, 32'(bus4.light), 32'h0);
    check({tag, " reset phase"}, 32'(bus4.phase), 32'd0);
    check({tag, " reset active_dir"}, 32'(bus4.active_dir), 32'd3);
    check({tag, " reset preempt_ack"}, 32'(bus4.preempt_ack), 32'd0);
    check({tag, " reset active_dir n3"}, 32'(bus3.active_dir), 32'd2);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    // Test 1: full fixed-cycle rotation, back to approach 0 after 32 cycles.
    do_reset("t1");
    rot(4, 35, 1'b0, 0);
    run("t1", 1'b0);
    // Test 2: only approach 2 requests, so it is the only one ever served.
    do_reset("t2");
    seg(1, 8'h04, 0, 0, 0, 0, 3, 0);
    for (int k = 0; k < 2; k++) begin
      seg(5, 8'h04, 0, 0, 0, 1, 2, 0);
      seg(2, 8'h04, 0, 0, 0, 2, 2, 0);
      seg(1, 8'h04, 0, 0, 0, 0, 2, 0);
    end
    seg(1, 8'h04, 0, 0, 0, 1, 2, 0);
    run("t2", 1'b0);
    // Test 3: preempt to approach 3 during the second green cycle of approach 0, held 10 cycles.
    do_reset("t3");
    seg(1, 0, 0, 3, 0, 0, 3, 0);
    seg(1, 0, 0, 3, 0, 1, 0, 0);
    seg(1, 0, 1, 3, 0, 1, 0, 0);
    seg(2, 0, 1, 3, 0, 2, 0, 0);
    seg(1, 0, 1, 3, 0, 0, 0, 0);
    seg(6, 0, 1, 3, 0, 1, 3, 1);
    seg(1, 0, 0, 3, 0, 1, 3, 1);
    seg(4, 0, 0, 3, 0, 1, 3, 0);
    seg(2, 0, 0, 3, 0, 2, 3, 0);
    seg(1, 0, 0, 3, 0, 0, 3, 0);
    seg(1, 0, 0, 3, 0, 1, 0, 0);
    run("t3", 1'b0);
    // Test 4: flash requested mid green of approach 1; blink 3/3; drop it and resume at approach 2.
    do_reset("t4");
    seg(1, 0, 0, 0, 0, 0, 3, 0);
    seg(5, 0, 0, 0, 0, 1, 0, 0);
    seg(2, 0, 0, 0, 0, 2, 0, 0);
    seg(1, 0, 0, 0, 0, 0, 0, 0);
    seg(2, 0, 0, 0, 0, 1, 1, 0);
    seg(3, 0, 0, 0, 1, 1, 1, 0);
    seg(2, 0, 0, 0, 1, 2, 1, 0);
    seg(1, 0, 0, 0, 1, 0, 1, 0);
    seg(3, 0, 0, 0, 1, 3, 1, 0, 1'b0);
    seg(3, 0, 0, 0, 1, 3, 1, 0, 1'b1);
    seg(2, 0, 0, 0, 1, 3, 1, 0, 1'b0);
    seg(1, 0, 0, 0, 0, 3, 1, 0, 1'b0);
    seg(1, 0, 0, 0, 0, 0, 1, 0);
    seg(1, 0, 0, 0, 0, 1, 2, 0);
    run("t4", 1'b0);
    // Test 5: asynchronous reset between clock edges during yellow.
    do_reset("t5");
    repeat (6) @(posedge clk);
    #1;
    check("t5 pre phase", 32'(bus4.phase), 32'd2);
    check("t5 pre light", 32'(bus4.light), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("t5 async light", 32'(bus4.light), 32'h0);
    check("t5 async phase", 32'(bus4.phase), 32'd0);
    check("t5 async active_dir", 32'(bus4.active_dir), 32'd3);
    do_reset("t5b");
    rot(4, 10, 1'b0, 0);
    run("t5 restart", 1'b0);
    // Test 6: three approaches, preempt_dir=3 is out of range and must be ignored.
    do_reset("t6");
    rot(3, 27, 1'b1, 3);
    run("t6", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Parametrised N-approach intersection controller and the next generation of the fixed two-way NS/EW sequencer. It serves one approach at a time through green, yellow and all-red phases. It adds demand-actuated skipping, emergency preemption and a flashing-yellow maintenance mode. It sits between the sensor/preempt front-end and the lamp drivers.

Parameters:
NUM_DIRS, 4, number of approaches (2..8)
GREEN_TIME, 5, green phase length in clk cycles (>=1)
YELLOW_TIME, 2, yellow phase length in cycles (>=1)
ALL_RED_TIME, 1, all-red clearance length in cycles (>=1)
FLASH_TIME, 3, half-period of flash blink in cycles (>=1)
DIR_W, $clog2(NUM_DIRS), approach index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
veh_req  in  NUM_DIRS  per-approach vehicle demand, level
preempt_valid  in  1  emergency preemption request, level
preempt_dir  in  DIR_W  approach to preempt to
flash_mode  in  1  maintenance flash request, level
light  out  2*NUM_DIRS  per approach [2i+1:2i]: 00 red, 01 yellow, 10 green, 11 dark
active_dir  out  DIR_W  approach currently or last served
phase  out  2  0 ALL_RED, 1 GREEN, 2 YELLOW, 3 FLASH
preempt_ack  out  1  high while green is held by preemption

Behaviour:
- Clock clk; reset is asynchronous, active-high. Reset sets: phase=ALL_RED, timer=ALL_RED_TIME-1, active_dir=NUM_DIRS-1, flash counter=0, all lights 00, preempt_ack=0.
- Outputs decode only from registered state (phase, active_dir, flash bit, preempt flag). There is no combinational path from any input.
- Each phase lasts exactly its TIME in cycles. The timer loads TIME-1 on entry and decrements. The transition is taken in the cycle where timer==0.
- preempt is "valid" only when preempt_valid=1 and preempt_dir<NUM_DIRS. An out-of-range preempt_dir is ignored completely.
- ALL_RED, at timer==0, evaluated in priority order:
  - Valid preempt: go to GREEN on preempt_dir.
  - Else flash_mode=1: go to FLASH.
  - Else go to GREEN on the round-robin winner. Search starts at active_dir+1, wraps, and checks active_dir last; the first approach with veh_req=1 wins. If veh_req==0 the winner is active_dir+1 mod NUM_DIRS (fixed-cycle fallback).
- GREEN:
  - Valid preempt for a different approach: go to YELLOW next cycle, cutting the remaining green.
  - Valid preempt for active_dir: timer reloads GREEN_TIME-1 every cycle and preempt_ack=1. After release, green lasts GREEN_TIME more cycles.
  - Otherwise timer==0: go to YELLOW.
- YELLOW: always runs to completion with no cut, then goes to ALL_RED.
- flash_mode has no effect in GREEN or YELLOW. It is acted on only at ALL_RED expiry, so it is safe to assert at any time.
- FLASH:
  - All approaches show 01 for FLASH_TIME cycles, then 11 for FLASH_TIME cycles, repeating. The first FLASH cycle shows 01.
  - Valid preempt or flash_mode=0: go to ALL_RED (timer reload); active_dir is unchanged.
- Light decode: active_dir shows 10 in GREEN and 01 in YELLOW; every other approach shows 00. In ALL_RED all approaches show 00.
- Invariant: at most one approach is non-red outside FLASH, and no green follows another green without an intervening YELLOW and ALL_RED.
- Reset mid-phase: all lights are 00 immediately (asynchronous), and the block restarts from the reset state.

Decomposition:
- traffic_pkg holds:
  - the phase_t enum (ALL_RED, GREEN, YELLOW, FLASH);
  - light code localparams LIGHT_RED/YELLOW/GREEN/DARK;
  - the function computing the timer width from the max of the TIME parameters.
- One sub-module, traffic_rr_select: a combinational round-robin finder. Inputs are req[NUM_DIRS] and last[DIR_W]; outputs are winner[DIR_W] and any_req.

Test Plan:
1. Defaults, veh_req=0, release reset -> 1 cycle all red; dir0 10 for 5 cycles; 01 for 2; all red 1; then dir1, dir2, dir3; full rotation = 32 cycles, back to dir0.
2. veh_req=4'b0100 held -> only approach 2 is ever green; repeating pattern green 5 / yellow 2 / all-red 1 on dir2; dirs 0, 1, 3 stay 00.
3. Preempt_dir=3 asserted in 2nd cycle of dir0 green, held 10 cycles -> dir0 yellow next cycle for 2, all red 1, dir3 green with preempt_ack=1 until release, then 5 more green cycles.
4. flash_mode=1 raised mid dir1 green -> green and yellow complete, all red 1, then all lights 01 for 3 cycles / 11 for 3 repeating; drop flash_mode -> all red 1, then dir2 green.
5. Async reset asserted mid-yellow between clock edges -> light=all 00 and phase=0 the same instant; after release, sequence restarts at dir0 as in test 1.
6. NUM_DIRS=4, preempt_valid=1, preempt_dir=... out-of-range value is not expressible in DIR_W=2, so rerun with NUM_DIRS=3, preempt_dir=3 -> ignored, normal rotation 0,1,2, preempt_ack stays 0.
